// File: rtl/vga_timing_if.sv
// Raster timing bundle between the timing generator (master) and the pixel/colour path (slave).
// The pixel-rate enable flows into the generator; positions, syncs and strobes flow out.
interface vga_timing_if;
   logic        pix_en;
   logic [10:0] h_cnt;
   logic [10:0] v_cnt;
   logic        hsync;
   logic        vsync;
   logic        active;
   logic        line_end;
   logic        frame_start;

   modport master (
      input  pix_en,
      output h_cnt, v_cnt, hsync, vsync, active, line_end, frame_start
   );

   modport slave (
      output pix_en,
      input  h_cnt, v_cnt, hsync, vsync, active, line_end, frame_start
   );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: h/v position counters with registered sync, active and strobes.
// Decodes are taken from the next-state counts so they line up with the counts shown each cycle.
module vga_timing_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter bit SYNC_POL = 1'b0
) (
   input  logic         clk,
   input  logic         rst_n,
   vga_timing_if.master vga
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   generate
      if (H_TOTAL > 2048 || V_TOTAL > 2048 ||
          H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
          V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_params
         $error("vga_timing_gen: totals must be <= 2048 and every timing parameter >= 1");
      end
   endgenerate

   localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
   localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
   localparam logic [10:0] H_VIS    = 11'(H_ACTIVE);
   localparam logic [10:0] V_VIS    = 11'(V_ACTIVE);
   localparam logic [10:0] HS_FIRST = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] HS_LAST  = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [10:0] VS_FIRST = 11'(V_ACTIVE + V_FP);
   localparam logic [10:0] VS_LAST  = 11'(V_ACTIVE + V_FP + V_SYNC - 1);

   logic [10:0] h_reg, h_next;
   logic [10:0] v_reg, v_next;
   logic        hsync_reg, hsync_next;
   logic        vsync_reg, vsync_next;
   logic        active_reg, active_next;
   logic        line_end_reg, line_end_next;
   logic        frame_start_reg, frame_start_next;
   logic        h_wrap;

   always_comb begin
      h_wrap = vga.pix_en && (h_reg == H_LAST);
      h_next = h_reg;
      v_next = v_reg;
      if (vga.pix_en) begin
         h_next = h_wrap ? 11'd0 : h_reg + 11'd1;
      end
      // Vertical advances in the same clk as the horizontal wrap, so (0,0) follows (H_LAST,V_LAST) directly.
      if (h_wrap) begin
         v_next = (v_reg == V_LAST) ? 11'd0 : v_reg + 11'd1;
      end

      hsync_next       = ((h_next >= HS_FIRST) && (h_next <= HS_LAST)) ? SYNC_POL : ~SYNC_POL;
      vsync_next       = ((v_next >= VS_FIRST) && (v_next <= VS_LAST)) ? SYNC_POL : ~SYNC_POL;
      active_next      = (h_next < H_VIS) && (v_next < V_VIS);
      line_end_next    = h_wrap;
      frame_start_next = h_wrap && (v_reg == V_LAST);
   end

   // Reset values equal the decode of (0,0) with both strobes idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_reg           <= 11'd0;
         v_reg           <= 11'd0;
         hsync_reg       <= ~SYNC_POL;
         vsync_reg       <= ~SYNC_POL;
         active_reg      <= 1'b1;
         line_end_reg    <= 1'b0;
         frame_start_reg <= 1'b0;
      end else begin
         h_reg           <= h_next;
         v_reg           <= v_next;
         hsync_reg       <= hsync_next;
         vsync_reg       <= vsync_next;
         active_reg      <= active_next;
         line_end_reg    <= line_end_next;
         frame_start_reg <= frame_start_next;
      end
   end

   assign vga.h_cnt       = h_reg;
   assign vga.v_cnt       = v_reg;
   assign vga.hsync       = hsync_reg;
   assign vga.vsync       = vsync_reg;
   assign vga.active      = active_reg;
   assign vga.line_end    = line_end_reg;
   assign vga.frame_start = frame_start_reg;

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Generates the VGA raster timing: the 11-bit horizontal and vertical position counters that the constant-match comparators decode. It also produces the hsync/vsync, active-video and frame/line strobes directly. It sits between the system clock domain's pixel-enable divider and the pixel/colour path. All outputs are registered so sync pins are glitch-free.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)
SYNC_POL, 0, asserted level of hsync/vsync (0 = active-low)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
pix_en  input  1  pixel-rate enable; counters advance only in cycles where it is 1
h_cnt  output  11  current horizontal position, 0..H_TOTAL-1
v_cnt  output  11  current vertical position, 0..V_TOTAL-1
hsync  output  1  horizontal sync, SYNC_POL when asserted
vsync  output  1  vertical sync, SYNC_POL when asserted
active  output  1  1 when h_cnt<H_ACTIVE and v_cnt<V_ACTIVE
line_end  output  1  one-clk pulse when h_cnt wraps to 0
frame_start  output  1  one-clk pulse when (h_cnt,v_cnt) wraps to (0,0)

Behaviour:
- Clocking: one clock, clk. Reset: rst_n, asynchronous, active-low.
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP. V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- Constraint: both totals <= 2048 and every parameter >= 1. Violation is an elaboration error.
- Reset values, applied asynchronously while rst_n=0: h_cnt=0, v_cnt=0, active=1, hsync=vsync=~SYNC_POL, line_end=0, frame_start=0.
- Reset values equal the decode of position (0,0), so the alignment rule holds from reset onward.
- pix_en=1 cycle:
  - h_cnt <= (h_cnt==H_TOTAL-1) ? 0 : h_cnt+1.
  - On h wrap: v_cnt <= (v_cnt==V_TOTAL-1) ? 0 : v_cnt+1. Otherwise v_cnt holds.
- pix_en=0 cycle: counters, hsync, vsync and active hold; line_end=0 and frame_start=0.
- Alignment: hsync, vsync and active are computed from next-state counts. They therefore describe the h_cnt/v_cnt presented in the same cycle (zero lag).
- hsync asserted iff H_ACTIVE+H_FP <= h_cnt <= H_ACTIVE+H_FP+H_SYNC-1.
- vsync asserted iff V_ACTIVE+V_FP <= v_cnt <= V_ACTIVE+V_FP+V_SYNC-1. vsync changes only together with a v_cnt change, i.e. at h_cnt=0.
- line_end: high for exactly one clk, in the cycle h_cnt first shows 0 after a wrap.
- frame_start: high for exactly one clk, in the cycle (0,0) is first shown after a wrap. It coincides with line_end.
- Neither strobe fires on reset release.
- Simultaneous h and v wrap happen in the same clk. There is no intermediate (0,V_TOTAL-1) state.
- Reset mid-line or mid-frame: outputs return to reset values immediately, independent of clk. After release, counting resumes from (0,0) on the first pix_en.
- Arithmetic: unsigned 11-bit. Counters never exceed TOTAL-1, so no overflow.
- pix_en may be 1 continuously (pixel clock = clk) or periodic (e.g. every 2nd clk).

Test Plan:
1. Defaults, pix_en=1 constant, reset released -> h_cnt runs 0..799 then 0, with line_end high exactly at that 0. hsync=0 for h_cnt 656..751 (96 clk), else 1. active=0 from h_cnt 640.
2. Defaults, run one full frame -> vsync=0 for v_cnt 490..491 (2×800 clk). frame_start pulses exactly 420000 clk apart. v_cnt peaks at 524. active never 1 for v_cnt>=480.
3. pix_en toggling 1,0,1,0 -> counters advance every 2nd clk. line_end/frame_start remain single-clk pulses. 840000 clk between frame_start pulses.
4. Assert rst_n=0 asynchronously (between clk edges) at h_cnt=300, v_cnt=200 -> outputs go to 0/0, active=1, hsync=vsync=1 without a clk edge. After release, no frame_start fires; the first pix_en gives h_cnt=1.
5. Override H=4/1/2/1, V=3/1/1/1, SYNC_POL=1 -> H_TOTAL=8, V_TOTAL=6. hsync=1 at h_cnt 5..6. vsync=1 at v_cnt 4. frame_start every 48 pix_en.
6. At (7,5) in the override config, apply one pix_en -> next clk shows (0,0) with line_end=frame_start=1, active=1, vsync=0.
